// File: rtl/seg7_scan_capture_if.sv
// Bus bundle between a multiplexed 7-segment scan source and the capture block.
// The scan side drives the active-low select/segment lines. The capture side
// returns the reconstructed frame.
interface seg7_scan_capture_if;
    logic [7:0]  i_sel;
    logic [7:0]  i_seg;
    logic [63:0] o_raw;
    logic [31:0] o_hex;
    logic [7:0]  o_hex_ok;
    logic        o_mode;
    logic        o_frame_valid;
    logic        o_sel_err;

    modport master (
        output i_sel, i_seg,
        input  o_raw, o_hex, o_hex_ok, o_mode, o_frame_valid, o_sel_err
    );

    modport slave (
        input  i_sel, i_seg,
        output o_raw, o_hex, o_hex_ok, o_mode, o_frame_valid, o_sel_err
    );
endinterface

// File: rtl/seg7_scan_capture.sv
// Receive side of a multiplexed 7-segment scan. The block samples the AN/SEG
// lines and waits until they have been quiet long enough to accept one digit
// per stable period. After all eight digits are seen it publishes the raw
// frame, the hex decode and the text/graph mode.
module seg7_scan_capture #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic               CLK100MHZ,
    input  logic               CPU_RESET,
    seg7_scan_capture_if.slave bus
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {S_WAIT, S_HOLD, S_PUBLISH} state_t;

    state_t      state, state_nxt;
    logic [15:0] sync_p0;
    logic [15:0] smp_p1;
    logic [7:0]  cnt;
    logic        stable;
    logic [7:0]  smp_sel;
    logic [7:0]  smp_seg;
    logic        sel_blank;
    logic        sel_onehot;
    logic [2:0]  dig_idx;
    logic [7:0]  seen;
    logic [7:0]  seen_upd;
    logic [63:0] frame_buf;
    logic        cap_en;
    logic        err_en;
    logic        pub_en;
    logic [31:0] hex_dec;
    logic [7:0]  ok_dec;

    // The result is {ok, nibble}. Every legal glyph has DP (bit 7) high,
    // so any byte with DP low falls through to the default.
    function automatic logic [4:0] decode_glyph(input logic [7:0] code);
        case (code)
            8'hC0:   return {1'b1, 4'h0};
            8'hF9:   return {1'b1, 4'h1};
            8'hA4:   return {1'b1, 4'h2};
            8'hB0:   return {1'b1, 4'h3};
            8'h99:   return {1'b1, 4'h4};
            8'h92:   return {1'b1, 4'h5};
            8'h82:   return {1'b1, 4'h6};
            8'hF8:   return {1'b1, 4'h7};
            8'h80:   return {1'b1, 4'h8};
            8'h90:   return {1'b1, 4'h9};
            8'h88:   return {1'b1, 4'hA};
            8'h83:   return {1'b1, 4'hB};
            8'hC6:   return {1'b1, 4'hC};
            8'hA1:   return {1'b1, 4'hD};
            8'h86:   return {1'b1, 4'hE};
            8'h8E:   return {1'b1, 4'hF};
            default: return 5'h00;
        endcase
    endfunction

    // Two-flop synchronizer on the raw pins; only smp_p1 is used further on
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            sync_p0 <= '0;
            smp_p1  <= '0;
        end else begin
            sync_p0 <= {bus.i_sel, bus.i_seg};
            smp_p1  <= sync_p0;
        end
    end

    // Stability counter. It follows the value being loaded into smp_p1, so
    // cnt == N-1 means smp_p1 has held its value for N cycles. It saturates
    // so that a long hold never wraps and triggers a second acceptance.
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            cnt <= '0;
        end else if (sync_p0 != smp_p1) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign stable     = (cnt == CNT_MAX);
    assign smp_sel    = smp_p1[15:8];
    assign smp_seg    = smp_p1[7:0];
    assign sel_blank  = &smp_sel;
    assign sel_onehot = $onehot(~smp_sel);
    assign seen_upd   = seen | (8'd1 << dig_idx);

    // Index of the low select bit. It is only meaningful when sel_onehot is set.
    always_comb begin
        dig_idx = '0;
        for (int k = 0; k < 8; k++) begin
            if (!smp_sel[k]) dig_idx = 3'(k);
        end
    end

    // FSM state register
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) state <= S_WAIT;
        else           state <= state_nxt;
    end

    // FSM next state. HOLD leaves as soon as the sample is no longer stable,
    // which gives one acceptance per stable period.
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT: begin
                if (stable) begin
                    if (sel_onehot && (&seen_upd)) state_nxt = S_PUBLISH;
                    else                           state_nxt = S_HOLD;
                end
            end
            S_HOLD:    if (!stable) state_nxt = S_WAIT;
            S_PUBLISH: state_nxt = S_HOLD;
            default:   state_nxt = S_WAIT;
        endcase
    end

    // FSM outputs: capture, select error and publish strobes
    always_comb begin
        cap_en = (state == S_WAIT) && stable && sel_onehot;
        err_en = (state == S_WAIT) && stable && !sel_onehot && !sel_blank;
        pub_en = (state == S_PUBLISH);
    end

    // Working frame buffer and the record of digits captured so far
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            frame_buf <= '0;
            seen      <= '0;
        end else if (pub_en) begin
            seen <= '0;
        end else if (cap_en) begin
            seen                     <= seen_upd;
            frame_buf[8*dig_idx +: 8] <= smp_seg;
        end
    end

    // Per-digit hex decode of the working buffer
    always_comb begin
        hex_dec = '0;
        ok_dec  = '0;
        for (int k = 0; k < 8; k++) begin
            {ok_dec[k], hex_dec[4*k +: 4]} = decode_glyph(frame_buf[8*k +: 8]);
        end
    end

    // Published outputs, updated together with the frame_valid pulse
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            bus.o_raw         <= '0;
            bus.o_hex         <= '0;
            bus.o_hex_ok      <= '0;
            bus.o_mode        <= 1'b0;
            bus.o_frame_valid <= 1'b0;
            bus.o_sel_err     <= 1'b0;
        end else begin
            bus.o_frame_valid <= pub_en;
            bus.o_sel_err     <= err_en;
            if (pub_en) begin
                bus.o_raw    <= frame_buf;
                bus.o_hex    <= hex_dec;
                bus.o_hex_ok <= ok_dec;
                bus.o_mode   <= ~&ok_dec;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture. A run-length based reference model is compared
// against every output on every cycle. Directed scans also carry
// hand-computed expectations.
module tb_seg7_scan_capture;

    localparam int STABLE = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_capture_if bus ();

    seg7_scan_capture #(.STABLE_CYCLES(STABLE)) dut (
        .CLK100MHZ (clk),
        .CPU_RESET (rst),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int err_cnt = 0;
    bit started = 1'b0;

    logic [7:0] glyphs [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [7:0] text_codes  [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] graph_codes [8] = '{8'h80, 8'hF8, 8'h82, 8'h7F, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: sampled value, run length, captured bytes and published frame
    logic [15:0] m_s0, m_s1;
    int          run;
    logic [63:0] m_buf, m_raw;
    logic [31:0] m_hex;
    logic [7:0]  m_ok, m_seen;
    logic        m_mode, m_fv, m_err, m_pend;

    always @(posedge clk) begin
        if (rst) begin
            m_s0 = '0; m_s1 = '0; run = 1;
            m_buf = '0; m_raw = '0; m_hex = '0; m_ok = '0; m_seen = '0;
            m_mode = 0; m_fv = 0; m_err = 0; m_pend = 0;
            started = 1'b1;
        end else begin
            m_fv  = m_pend;
            m_err = 1'b0;
            if (m_pend) begin
                m_raw = m_buf;
                m_hex = '0;
                m_ok  = '0;
                for (int d = 0; d < 8; d++)
                    for (int g = 0; g < 16; g++)
                        if (m_buf[8*d +: 8] == glyphs[g]) begin
                            m_hex[4*d +: 4] = 4'(g);
                            m_ok[d] = 1'b1;
                        end
                m_mode = (m_ok != 8'hFF);
                m_seen = '0;
                m_pend = 1'b0;
            end else if (run == STABLE) begin
                int zeros;
                int idx;
                zeros = 0;
                idx = 0;
                for (int b = 0; b < 8; b++)
                    if (!m_s1[8+b]) begin zeros++; idx = b; end
                if (zeros == 1) begin
                    m_buf[8*idx +: 8] = m_s1[7:0];
                    m_seen[idx] = 1'b1;
                    if (m_seen == 8'hFF) m_pend = 1'b1;
                end else if (zeros > 1) begin
                    m_err = 1'b1;
                end
            end
            if (m_s0 == m_s1) run++;
            else              run = 1;
            m_s1 = m_s0;
            m_s0 = {bus.i_sel, bus.i_seg};
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            chk("raw",   bus.o_raw, m_raw);
            chk("hex",   64'(bus.o_hex), 64'(m_hex));
            chk("hexok", 64'(bus.o_hex_ok), 64'(m_ok));
            chk("mode",  64'(bus.o_mode), 64'(m_mode));
            chk("fv",    64'(bus.o_frame_valid), 64'(m_fv));
            chk("selerr", 64'(bus.o_sel_err), 64'(m_err));
        end
    end

    // Pulse counters, sampled at the active edge
    always @(posedge clk) begin
        if (bus.o_frame_valid === 1'b1) fv_cnt++;
        if (bus.o_sel_err === 1'b1)     err_cnt++;
    end

    task automatic hold(input logic [7:0] s, input logic [7:0] g, input int n);
        bus.i_sel = s;
        bus.i_seg = g;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan_digit(input int k, input logic [7:0] code);
        hold(~(8'd1 << k), code, 64);
        hold(8'hFF, 8'hFF, 4);
    endtask

    task automatic scan_range(input logic [7:0] codes [8], input int lo, input int hi);
        for (int k = lo; k <= hi; k++) scan_digit(k, codes[k]);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_raw"},   bus.o_raw, 64'h0);
        chk({tag, "_hex"},   64'(bus.o_hex), 64'h0);
        chk({tag, "_hexok"}, 64'(bus.o_hex_ok), 64'h0);
        chk({tag, "_mode"},  64'(bus.o_mode), 64'h0);
        chk({tag, "_fv"},    64'(bus.o_frame_valid), 64'h0);
        chk({tag, "_err"},   64'(bus.o_sel_err), 64'h0);
    endtask

    initial begin
        int fv0;
        int er0;
        bus.i_sel = 8'hFF;
        bus.i_seg = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero("reset");

        // Text frame 0x12345678
        fv0 = fv_cnt;
        scan_range(text_codes, 0, 7);
        chk("text_fv_count", 64'(fv_cnt - fv0), 64'd1);
        chk("text_hex",   64'(bus.o_hex), 64'h12345678);
        chk("text_hexok", 64'(bus.o_hex_ok), 64'hFF);
        chk("text_mode",  64'(bus.o_mode), 64'd0);
        chk("text_byte0", 64'(bus.o_raw[7:0]), 64'h80);
        chk("text_raw",   bus.o_raw, 64'hF9A4B099_9282F880);

        // Graph frame: digit 3 carries 0x7F
        fv0 = fv_cnt;
        scan_range(graph_codes, 0, 7);
        chk("graph_fv_count", 64'(fv_cnt - fv0), 64'd1);
        chk("graph_hexok", 64'(bus.o_hex_ok), 64'hF7);
        chk("graph_nib3",  64'(bus.o_hex[15:12]), 64'h0);
        chk("graph_hex",   64'(bus.o_hex), 64'h12340678);
        chk("graph_byte3", 64'(bus.o_raw[31:24]), 64'h7F);
        chk("graph_mode",  64'(bus.o_mode), 64'd1);

        // Illegal select held 32 cycles
        er0 = err_cnt;
        fv0 = fv_cnt;
        hold(8'hFC, 8'h00, 32);
        hold(8'hFF, 8'hFF, 4);
        chk("illegal_err_count", 64'(err_cnt - er0), 64'd1);
        chk("illegal_fv_count",  64'(fv_cnt - fv0), 64'd0);
        chk("illegal_raw_kept",  bus.o_raw, 64'hF9A4B099_7F82F880);

        // Glitch: digit 2 held one cycle short, then the rest of the frame
        fv0 = fv_cnt;
        hold(8'hFB, 8'h88, STABLE - 1);
        hold(8'hFF, 8'hFF, 4);
        scan_range(text_codes, 0, 1);
        scan_range(text_codes, 3, 7);
        chk("glitch_no_frame", 64'(fv_cnt - fv0), 64'd0);
        hold(8'hFB, 8'h82, STABLE);
        hold(8'hFF, 8'hFF, 8);
        chk("glitch_exact_frame", 64'(fv_cnt - fv0), 64'd1);
        chk("glitch_byte2", 64'(bus.o_raw[23:16]), 64'h82);
        chk("glitch_hex",   64'(bus.o_hex), 64'h12345678);

        // Reset mid-frame, then digits 5..7 first so a stale seen mask would publish early
        scan_range(text_codes, 0, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midreset");
        fv0 = fv_cnt;
        scan_range(text_codes, 5, 7);
        chk("midreset_partial", 64'(fv_cnt - fv0), 64'd0);
        scan_range(text_codes, 0, 4);
        chk("midreset_fv_count", 64'(fv_cnt - fv0), 64'd1);
        chk("midreset_hex", 64'(bus.o_hex), 64'h12345678);

        // Out of order with a duplicate of digit 0 overwritten by C6
        fv0 = fv_cnt;
        scan_digit(7, 8'hF9);
        scan_digit(0, 8'h80);
        scan_digit(0, 8'hC6);
        scan_range(text_codes, 1, 6);
        chk("ooo_fv_count", 64'(fv_cnt - fv0), 64'd1);
        chk("ooo_nib0",  64'(bus.o_hex[3:0]), 64'hC);
        chk("ooo_hex",   64'(bus.o_hex), 64'h1234567C);
        chk("ooo_byte0", 64'(bus.o_raw[7:0]), 64'hC6);

        // Long holds: the counter must saturate, not wrap into a second acceptance
        er0 = err_cnt;
        hold(8'hFC, 8'h00, 1000);
        hold(8'hFF, 8'hFF, 4);
        chk("long_err_count", 64'(err_cnt - er0), 64'd1);
        fv0 = fv_cnt;
        hold(8'hFE, 8'h80, 1000);
        hold(8'hFF, 8'hFF, 4);
        chk("long_fv_count", 64'(fv_cnt - fv0), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive-side counterpart of the team's multiplexed 7-segment scan driver.
- Samples the active-low digit-select (AN) and segment (SEG) lines and rejects transitions and glitches.
- Reconstructs the full 8-digit frame as raw segment bytes, plus a decoded hex word where the codes allow it.
- Used for on-board loopback self-test and as a monitor in display-path benches.

Parameters:
- STABLE_CYCLES, 16: consecutive identical synchronized samples required before a digit is accepted. Legal range is 2 to 255.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz.
- CPU_RESET  input  1  reset; synchronous, active-high.
- i_sel  input  8  sampled digit select, active-low; bit k low selects digit k.
- i_seg  input  8  sampled segment lines, active-low; bit 7 is DP.
- o_raw  output  64  last complete frame; digit k occupies bits [8k+7:8k].
- o_hex  output  32  decoded nibbles; digit k occupies bits [4k+3:4k].
- o_hex_ok  output  8  bit k = 1 when digit k decoded to a legal hex glyph.
- o_mode  output  1  0 = text frame (all digits decoded), 1 = graph frame.
- o_frame_valid  output  1  one-cycle pulse when o_raw, o_hex, o_hex_ok and o_mode update.
- o_sel_err  output  1  one-cycle pulse on an accepted sample with more than one select bit low.

Behaviour:
- Reset: all outputs are 0 (o_raw=0, o_hex=0, o_hex_ok=0, o_mode=0, both pulses 0). Working buffer, seen mask, stability counter, sync flops and the FSM also clear. The FSM returns to S_WAIT.
- Reset mid-frame discards the partial frame. The next o_frame_valid requires all 8 digits to be captured again.
- Synchronizer: {i_sel,i_seg} passes through 2 flops. Only the synchronized value (smp) is used downstream.
- Stability counter (8-bit, saturating):
  - Cleared to 0 when smp differs from the previous cycle's smp.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
  - "stable" = counter == STABLE_CYCLES-1, i.e. smp unchanged for STABLE_CYCLES consecutive cycles.
- Select classification of smp.sel:
  - 8'hFF: blank, legal; nothing is captured.
  - Exactly one bit low: digit index k.
  - Two or more bits low: illegal.
- FSM states: S_WAIT, S_HOLD, S_PUBLISH.
  - S_WAIT, stable and sel one-hot:
    - Write smp.seg into working byte k and set seen[k].
    - Go to S_PUBLISH if seen becomes 8'hFF, else S_HOLD.
  - S_WAIT, stable and sel illegal: pulse o_sel_err for one cycle, go to S_HOLD, capture nothing.
  - S_WAIT, stable and sel blank: go to S_HOLD.
  - S_HOLD: stay until the counter clears (smp changes), then go to S_WAIT. This gives exactly one capture or error per stable period.
  - S_PUBLISH (one cycle):
    - Copy the working buffer to o_raw and load decoded o_hex/o_hex_ok.
    - o_mode = ~&decoded_ok.
    - Assert o_frame_valid, clear seen, go to S_HOLD.
- Latency: an input held constant from cycle t is captured at cycle t+2+STABLE_CYCLES. The final digit of a frame produces o_frame_valid one cycle after its capture.
- Repeat capture of a digit already in seen overwrites its byte and leaves seen unchanged. Scan order is irrelevant.
- Decode, applied per byte at publish:
  - DP (bit 7) must be 1.
  - Codes: C0→0, F9→1, A4→2, B0→3, 99→4, 92→5, 82→6, F8→7, 80→8, 90→9, 88→A, 83→B, C6→C, A1→D, 86→E, 8E→F.
  - Any other byte gives nibble 0 and ok bit 0.
- o_raw/o_hex/o_hex_ok/o_mode hold their values between publishes.

Test Plan:
- Text frame: scan digits 0..7 with codes for 0x12345678 (digit0=80 "8", ..., digit7=F9 "1"), each held 64 cycles with a 4-cycle blank (sel FF) between. Required: a single o_frame_valid after digit 7 capture, o_hex=0x12345678, o_hex_ok=FF, o_mode=0, o_raw byte0=0x80.
- Graph frame: same scan, but digit 3 = 0x7F (DP on). Required: o_hex_ok=F7, o_hex[15:12]=0, o_raw[31:24]=0x7F, o_mode=1.
- Glitch rejection: hold digit 2 for STABLE_CYCLES-1 synchronized cycles, then change. Required: seen[2] not set and no capture. Holding exactly STABLE_CYCLES cycles is captured.
- Illegal select: sel=8'hFC held 32 cycles. Required: exactly one o_sel_err pulse, no byte written, seen unchanged.
- Reset mid-frame: capture digits 0..4, assert CPU_RESET for 1 cycle, then scan all 8. Required: all outputs 0 after reset and exactly one o_frame_valid, only after all 8 new digits.
- Out-of-order scan with duplicates: order 7,0,0(new value 0xC6),1..6. Required: o_hex[3:0]=C, a single o_frame_valid, counter saturates without wrapping during a 1000-cycle hold.
